// File: rtl/arcino_defines.sv
// ---------------------------------------------------------------------------
// arcino_defines
//   Constants shared across ARCINO blocks.
//   INSTR_ERR_RDATA : instruction word returned for a fetch outside the
//                     instruction-memory window. It decodes as illegal, so the
//                     ID stage and the memory responder agree on one value.
// ---------------------------------------------------------------------------
package arcino_defines;

    localparam logic [31:0] INSTR_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/arcino_ram_1r1w.sv
// ---------------------------------------------------------------------------
// arcino_ram_1r1w
//   Inferable word RAM with 2**AddrWidth 32-bit words, one synchronous read
//   port and one write port. Contents and read register are not reset.
//   A read and a write to the same word on one edge return the old data.
// Ports:
//   clk_i  : clock
//   re     : read enable; rdata updates only on an enabled edge
//   raddr  : read word address
//   rdata  : registered read data (holds between reads)
//   we     : write enable
//   waddr  : write word address
//   wdata  : write data
// ---------------------------------------------------------------------------
module arcino_ram_1r1w #(
    parameter int unsigned AddrWidth = 12
) (
    input  logic                 clk_i,
    input  logic                 re,
    input  logic [AddrWidth-1:0] raddr,
    output logic [31:0]          rdata,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [31:0]          wdata
);

    logic [31:0] mem [2**AddrWidth];

    // Non-blocking update of both mem and rdata gives read-before-write.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/arcino_instr_mem_resp.sv
// ---------------------------------------------------------------------------
// arcino_instr_mem_resp
//   Responder end of the instruction-fetch req/gnt/rvalid protocol, backed by
//   an internal word-addressed RAM filled through a side-band load port.
//
//   Handshake: a request is accepted on a clock edge where instr_req_i and
//   instr_gnt_o are both high; only then is instr_addr_i sampled. Every
//   accepted request produces exactly one single-cycle instr_rvalid_o pulse,
//   in order, Latency cycles later. The core never backpressures rvalid.
//   Ungranted requests leave no state behind.
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   instr_req_i     : fetch request
//   instr_addr_i    : fetch byte address (bits [1:0] ignored)
//   instr_gnt_o     : combinational grant
//   instr_rvalid_o  : response valid pulse
//   instr_rdata_o   : response data (holds last value between responses)
//   instr_err_o     : out-of-window response, qualified by rvalid
//   stall_i         : forces grant low this cycle
//   load_we_i       : load-port write enable
//   load_addr_i     : load-port word address
//   load_wdata_i    : load-port write data
// ---------------------------------------------------------------------------
module arcino_instr_mem_resp
    import arcino_defines::*;
#(
    parameter int unsigned AddrWidth      = 12,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_req_i,
    input  logic [31:0]          instr_addr_i,
    output logic                 instr_gnt_o,
    output logic                 instr_rvalid_o,
    output logic [31:0]          instr_rdata_o,
    output logic                 instr_err_o,
    input  logic                 stall_i,
    input  logic                 load_we_i,
    input  logic [AddrWidth-1:0] load_addr_i,
    input  logic [31:0]          load_wdata_i
);

    localparam int unsigned          CntWidth    = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0]  CntMax      = CntWidth'(MaxOutstanding);
    localparam logic [31:0]          WindowBytes = 32'd4 << AddrWidth;

    logic [CntWidth-1:0] cnt_q;
    logic                accept;
    logic                retire;
    logic [31:0]         offset;
    logic                in_range;
    logic [31:0]         ram_rdata;

    // Stage 0: RAM read register plus its valid/err flags.
    logic                vld0_q;
    logic                err0_q;
    logic                zero0_q;   // stage-0 data forced to INSTR_ERR_RDATA
    logic [31:0]         data0;

    logic                out_valid;
    logic                out_err;
    logic [31:0]         out_data;

    // ---------------- grant / window ----------------
    // Addresses below BaseAddr wrap to large offsets and fall out of range.
    assign offset   = instr_addr_i - BaseAddr;
    assign in_range = offset < WindowBytes;

    assign retire      = out_valid;
    // The retire term lets a new request in on the same cycle a slot frees.
    assign instr_gnt_o = rst_ni & instr_req_i & ~stall_i & ((cnt_q < CntMax) | retire);
    assign accept      = instr_gnt_o;

    // ---------------- outstanding counter ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept && !retire) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end else if (!accept && retire) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    // ---------------- RAM ----------------
    arcino_ram_1r1w #(
        .AddrWidth (AddrWidth)
    ) u_ram (
        .clk_i (clk_i),
        .re    (accept & in_range),
        .raddr (offset[AddrWidth+1:2]),
        .rdata (ram_rdata),
        .we    (load_we_i),
        .waddr (load_addr_i),
        .wdata (load_wdata_i)
    );

    // zero0_q resets high so the output data is 0 after reset even though the
    // RAM read register itself is never reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld0_q  <= 1'b0;
            err0_q  <= 1'b0;
            zero0_q <= 1'b1;
        end else begin
            vld0_q <= accept;
            if (accept) begin
                err0_q  <= ~in_range;
                zero0_q <= ~in_range;
            end
        end
    end

    assign data0 = zero0_q ? INSTR_ERR_RDATA : ram_rdata;

    // ---------------- latency shift stages ----------------
    if (Latency == 1) begin : g_direct
        assign out_valid = vld0_q;
        assign out_err   = err0_q;
        assign out_data  = data0;
    end else begin : g_shift
        logic        sv_q [Latency-1];
        logic        se_q [Latency-1];
        logic [31:0] sd_q [Latency-1];

        // err/data advance only with a valid beat so the last stage holds the
        // previous response between pulses.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k < Latency - 1; k++) begin
                    sv_q[k] <= 1'b0;
                    se_q[k] <= 1'b0;
                    sd_q[k] <= '0;
                end
            end else begin
                sv_q[0] <= vld0_q;
                if (vld0_q) begin
                    se_q[0] <= err0_q;
                    sd_q[0] <= data0;
                end
                for (int k = 1; k < Latency - 1; k++) begin
                    sv_q[k] <= sv_q[k-1];
                    if (sv_q[k-1]) begin
                        se_q[k] <= se_q[k-1];
                        sd_q[k] <= sd_q[k-1];
                    end
                end
            end
        end

        assign out_valid = sv_q[Latency-2];
        assign out_err   = se_q[Latency-2];
        assign out_data  = sd_q[Latency-2];
    end

    assign instr_rvalid_o = out_valid;
    assign instr_err_o    = out_valid & out_err;
    assign instr_rdata_o  = out_data;

    // ---------------- assertions ----------------
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntMax);
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(retire && !accept && (cnt_q == '0)));
    a_gnt_needs_req: assert property (@(posedge clk_i)
        instr_gnt_o |-> instr_req_i);

endmodule

// File: tb/tb_arcino_instr_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_arcino_instr_mem_resp
//   Three responder instances share one clock:
//     ua : Base 0,      AddrWidth 12, Latency 1, MaxOutstanding 2
//     ub : Base 0,      AddrWidth 12, Latency 3, MaxOutstanding 1
//     uc : Base 0x1000, AddrWidth 10, Latency 3, MaxOutstanding 2
//   Inputs are driven 1 ns after the rising edge, outputs checked on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_arcino_instr_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rst_n;
    logic rst_c;

    // ---- instance a ----
    logic        req_a, gnt_a, rvalid_a, err_a, stall_a, we_a;
    logic [31:0] addr_a, rdata_a, wdata_a;
    logic [11:0] laddr_a;
    // ---- instance b ----
    logic        req_b, gnt_b, rvalid_b, err_b, stall_b, we_b;
    logic [31:0] addr_b, rdata_b, wdata_b;
    logic [11:0] laddr_b;
    // ---- instance c ----
    logic        req_c, gnt_c, rvalid_c, err_c, stall_c, we_c;
    logic [31:0] addr_c, rdata_c, wdata_c;
    logic [9:0]  laddr_c;

    arcino_instr_mem_resp #(
        .AddrWidth(12), .BaseAddr(32'h0000_0000), .Latency(1), .MaxOutstanding(2)
    ) ua (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_a), .instr_addr_i(addr_a),
        .instr_gnt_o(gnt_a), .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a),
        .instr_err_o(err_a), .stall_i(stall_a), .load_we_i(we_a),
        .load_addr_i(laddr_a), .load_wdata_i(wdata_a)
    );

    arcino_instr_mem_resp #(
        .AddrWidth(12), .BaseAddr(32'h0000_0000), .Latency(3), .MaxOutstanding(1)
    ) ub (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req_b), .instr_addr_i(addr_b),
        .instr_gnt_o(gnt_b), .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b),
        .instr_err_o(err_b), .stall_i(stall_b), .load_we_i(we_b),
        .load_addr_i(laddr_b), .load_wdata_i(wdata_b)
    );

    arcino_instr_mem_resp #(
        .AddrWidth(10), .BaseAddr(32'h0000_1000), .Latency(3), .MaxOutstanding(2)
    ) uc (
        .clk_i(clk), .rst_ni(rst_c), .instr_req_i(req_c), .instr_addr_i(addr_c),
        .instr_gnt_o(gnt_c), .instr_rvalid_o(rvalid_c), .instr_rdata_o(rdata_c),
        .instr_err_o(err_c), .stall_i(stall_c), .load_we_i(we_c),
        .load_addr_i(laddr_c), .load_wdata_i(wdata_c)
    );

    // ---------------- clock/phase helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ---------------- reset ----------------
    task automatic test_reset();
        rst_n = 1'b0; rst_c = 1'b0;
        req_a = 1'b1; addr_a = 32'h0; stall_a = 1'b0; we_a = 1'b0; laddr_a = '0; wdata_a = '0;
        req_b = 1'b1; addr_b = 32'h0; stall_b = 1'b0; we_b = 1'b0; laddr_b = '0; wdata_b = '0;
        req_c = 1'b1; addr_c = 32'h1000; stall_c = 1'b0; we_c = 1'b0; laddr_c = '0; wdata_c = '0;
        mid();
        total++; if (gnt_a !== 1'b0) begin bad++; $display("FAIL reset_gnt_a: got %b want 0", gnt_a); end
        total++; if (gnt_b !== 1'b0) begin bad++; $display("FAIL reset_gnt_b: got %b want 0", gnt_b); end
        total++; if (gnt_c !== 1'b0) begin bad++; $display("FAIL reset_gnt_c: got %b want 0", gnt_c); end
        total++; if ({rvalid_a, err_a, rdata_a} !== 34'h0) begin bad++; $display("FAIL reset_out_a: rvalid=%b err=%b rdata=%h want all 0", rvalid_a, err_a, rdata_a); end
        total++; if ({rvalid_b, err_b, rdata_b} !== 34'h0) begin bad++; $display("FAIL reset_out_b: rvalid=%b err=%b rdata=%h want all 0", rvalid_b, err_b, rdata_b); end
        total++; if ({rvalid_c, err_c, rdata_c} !== 34'h0) begin bad++; $display("FAIL reset_out_c: rvalid=%b err=%b rdata=%h want all 0", rvalid_c, err_c, rdata_c); end
        tick();
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        rst_n = 1'b1; rst_c = 1'b1;
    endtask

    // Words 0..5: a = A0..A4,55  b = B0..B5  c = C0..C5
    task automatic preload();
        for (int i = 0; i < 6; i++) begin
            tick();
            we_a = 1'b1; laddr_a = 12'(i); wdata_a = (i == 5) ? 32'h55 : 32'hA0 + 32'(i);
            we_b = 1'b1; laddr_b = 12'(i); wdata_b = 32'hB0 + 32'(i);
            we_c = 1'b1; laddr_c = 10'(i); wdata_c = 32'hC0 + 32'(i);
        end
        tick();
        we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    endtask

    // ---------------- back-to-back stream, Latency 1 ----------------
    task automatic test_stream();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_a = 1'b1; addr_a = 32'(4 * i);
            mid();
            total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL stream_gnt[%0d]: got %b want 1", i, gnt_a); end
            if (i > 0) begin
                exp = 32'hA0 + 32'(i) - 32'd1;
                total++; if (rvalid_a !== 1'b1 || rdata_a !== exp || err_a !== 1'b0) begin bad++; $display("FAIL stream_resp[%0d]: rvalid=%b rdata=%h err=%b want 1 %h 0", i, rvalid_a, rdata_a, err_a, exp); end
            end
        end
        tick();
        req_a = 1'b0;
        mid();
        total++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hA3) begin bad++; $display("FAIL stream_last: rvalid=%b rdata=%h want 1 000000a3", rvalid_a, rdata_a); end
        tick();
        mid();
        total++; if (rvalid_a !== 1'b0 || rdata_a !== 32'hA3 || err_a !== 1'b0) begin bad++; $display("FAIL stream_hold: rvalid=%b rdata=%h err=%b want 0 000000a3 0", rvalid_a, rdata_a, err_a); end
    endtask

    // ---------------- load port read-before-write ----------------
    task automatic test_rbw();
        tick();
        req_a = 1'b1; addr_a = 32'd20; we_a = 1'b1; laddr_a = 12'd5; wdata_a = 32'hDEAD;
        mid();
        total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL rbw_gnt: got %b want 1", gnt_a); end
        tick();
        req_a = 1'b0; we_a = 1'b0;
        mid();
        total++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h55) begin bad++; $display("FAIL rbw_old: rvalid=%b rdata=%h want 1 00000055", rvalid_a, rdata_a); end
        tick();
        req_a = 1'b1; addr_a = 32'd20;
        mid();
        total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL rbw_gnt2: got %b want 1", gnt_a); end
        tick();
        req_a = 1'b0; we_a = 1'b1; laddr_a = 12'd5; wdata_a = 32'hBEEF;
        mid();
        total++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEAD) begin bad++; $display("FAIL rbw_new: rvalid=%b rdata=%h want 1 0000dead", rvalid_a, rdata_a); end
        tick();
        we_a = 1'b0;
        mid();
        total++; if (rvalid_a !== 1'b0) begin bad++; $display("FAIL rbw_idle: rvalid=%b want 0", rvalid_a); end
    endtask

    // ---------------- stall injection ----------------
    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            tick();
            req_a = 1'b1; stall_a = 1'b1; addr_a = 32'(4 * i);
            mid();
            total++; if (gnt_a !== 1'b0 || rvalid_a !== 1'b0) begin bad++; $display("FAIL stall[%0d]: gnt=%b rvalid=%b want 0 0", i, gnt_a, rvalid_a); end
        end
        tick();
        stall_a = 1'b0; addr_a = 32'd8;
        mid();
        total++; if (gnt_a !== 1'b1) begin bad++; $display("FAIL stall_resume: gnt=%b want 1", gnt_a); end
        tick();
        req_a = 1'b0;
        mid();
        total++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hA2) begin bad++; $display("FAIL stall_resp: rvalid=%b rdata=%h want 1 000000a2", rvalid_a, rdata_a); end
    endtask

    // ---------------- Latency 3, MaxOutstanding 1 ----------------
    task automatic test_latency3();
        logic exp_g, exp_v;
        for (int c = 0; c < 7; c++) begin
            tick();
            req_b = 1'b1; addr_b = 32'd4;
            mid();
            exp_g = (c % 3) == 0;
            exp_v = (c >= 3) && ((c % 3) == 0);
            total++; if (gnt_b !== exp_g) begin bad++; $display("FAIL lat3_gnt[%0d]: got %b want %b", c, gnt_b, exp_g); end
            total++; if (rvalid_b !== exp_v || (exp_v && rdata_b !== 32'hB1)) begin bad++; $display("FAIL lat3_rvalid[%0d]: rvalid=%b rdata=%h want %b 000000b1", c, rvalid_b, rdata_b, exp_v); end
        end
        for (int c = 7; c < 10; c++) begin
            tick();
            req_b = 1'b0;
            mid();
            exp_v = (c == 9);
            total++; if (rvalid_b !== exp_v || (exp_v && rdata_b !== 32'hB1)) begin bad++; $display("FAIL lat3_drain[%0d]: rvalid=%b rdata=%h want %b 000000b1", c, rvalid_b, rdata_b, exp_v); end
        end
    endtask

    // ---------------- window check, Base 0x1000 ----------------
    task automatic test_window();
        tick(); req_c = 1'b1; addr_c = 32'h0000_0FFC;
        mid();
        total++; if (gnt_c !== 1'b1) begin bad++; $display("FAIL win_gnt_low: got %b want 1", gnt_c); end
        tick(); addr_c = 32'h0000_5000;
        mid();
        total++; if (gnt_c !== 1'b1) begin bad++; $display("FAIL win_gnt_high: got %b want 1", gnt_c); end
        tick(); req_c = 1'b0;
        mid();
        total++; if (rvalid_c !== 1'b0) begin bad++; $display("FAIL win_early: rvalid=%b want 0", rvalid_c); end
        for (int i = 0; i < 2; i++) begin
            tick();
            mid();
            total++; if (rvalid_c !== 1'b1 || rdata_c !== 32'h0 || err_c !== 1'b1) begin bad++; $display("FAIL win_err[%0d]: rvalid=%b rdata=%h err=%b want 1 00000000 1", i, rvalid_c, rdata_c, err_c); end
        end
        tick(); req_c = 1'b1; addr_c = 32'h0000_1004;
        mid();
        total++; if (gnt_c !== 1'b1 || rvalid_c !== 1'b0 || err_c !== 1'b0) begin bad++; $display("FAIL win_in_gnt: gnt=%b rvalid=%b err=%b want 1 0 0", gnt_c, rvalid_c, err_c); end
        tick(); req_c = 1'b0;
        mid();
        tick();
        mid();
        total++; if (rvalid_c !== 1'b0 || err_c !== 1'b0) begin bad++; $display("FAIL win_gap: rvalid=%b err=%b want 0 0", rvalid_c, err_c); end
        tick();
        mid();
        total++; if (rvalid_c !== 1'b1 || rdata_c !== 32'hC1 || err_c !== 1'b0) begin bad++; $display("FAIL win_in_resp: rvalid=%b rdata=%h err=%b want 1 000000c1 0", rvalid_c, rdata_c, err_c); end
    endtask

    // ---------------- reset with responses in flight ----------------
    task automatic test_reset_mid();
        tick(); req_c = 1'b1; addr_c = 32'h0000_1000;
        mid();
        total++; if (gnt_c !== 1'b1) begin bad++; $display("FAIL rmid_gnt0: got %b want 1", gnt_c); end
        tick(); addr_c = 32'h0000_1004;
        mid();
        total++; if (gnt_c !== 1'b1) begin bad++; $display("FAIL rmid_gnt1: got %b want 1", gnt_c); end
        tick(); req_c = 1'b0; rst_c = 1'b0;
        mid();
        total++; if ({gnt_c, rvalid_c, err_c, rdata_c} !== 35'h0) begin bad++; $display("FAIL rmid_in_reset: gnt=%b rvalid=%b err=%b rdata=%h want all 0", gnt_c, rvalid_c, err_c, rdata_c); end
        tick(); rst_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            total++; if ({rvalid_c, err_c, rdata_c} !== 34'h0) begin bad++; $display("FAIL rmid_after[%0d]: rvalid=%b err=%b rdata=%h want all 0", i, rvalid_c, err_c, rdata_c); end
            tick();
        end
        req_c = 1'b1; addr_c = 32'h0000_1008;
        mid();
        total++; if (gnt_c !== 1'b1) begin bad++; $display("FAIL rmid_regnt: got %b want 1", gnt_c); end
        tick(); req_c = 1'b0;
        mid();
        tick();
        mid();
        total++; if (rvalid_c !== 1'b0) begin bad++; $display("FAIL rmid_early: rvalid=%b want 0", rvalid_c); end
        tick();
        mid();
        total++; if (rvalid_c !== 1'b1 || rdata_c !== 32'hC2 || err_c !== 1'b0) begin bad++; $display("FAIL rmid_resp: rvalid=%b rdata=%h err=%b want 1 000000c2 0", rvalid_c, rdata_c, err_c); end
    endtask

    initial begin
        test_reset();
        preload();
        test_stream();
        test_rbw();
        test_stall();
        test_latency3();
        test_window();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arcino_instr_mem_resp.md
# arcino_instr_mem_resp

Responder end of the ARCINO instruction-fetch req/gnt/rvalid protocol. It accepts fetch requests from the core's IF stage, grants them subject to outstanding-request capacity and an external stall, and returns read data from an internal word-addressed instruction RAM in order, after a fixed latency. A side-band load port fills the RAM before or during execution. It is used as the tightly-coupled instruction memory in simulation and small FPGA builds.

## Interface
- AddrWidth, 12: word-address bits; RAM holds 2**AddrWidth 32-bit words (16 KiB by default).
- BaseAddr, 32'h0000_0000: byte base address of the RAM window; must be aligned to 4*2**AddrWidth.
- Latency, 1: cycles from accept to rvalid; legal values 1..4.
- MaxOutstanding, 2: maximum accepted-but-unreturned requests; legal values 1..Latency+1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- instr_req_i  in  1  fetch request from the core.
- instr_addr_i  in  32  fetch byte address; bits [1:0] are ignored.
- instr_gnt_o  out  1  request accepted this cycle; combinational.
- instr_rvalid_o  out  1  response valid, a one-cycle pulse per accepted request.
- instr_rdata_o  out  32  response data.
- instr_err_o  out  1  response is for an out-of-window address; qualified by rvalid.
- stall_i  in  1  forces instr_gnt_o low; used for grant-stall injection.
- load_we_i  in  1  load-port word write.
- load_addr_i  in  AddrWidth  load-port word address.
- load_wdata_i  in  32  load-port write data.

## Operation
- Accept: instr_gnt_o = rst_ni & instr_req_i & ~stall_i & (cnt_q < MaxOutstanding | retire). Here retire = instr_rvalid_o this cycle. A request is accepted on the clock edge where req & gnt are both high; the address is sampled only at that edge.
- Outstanding counter cnt_q, width $clog2(MaxOutstanding+1):
  - +1 on accept, -1 on retire, unchanged when both occur.
  - Never exceeds MaxOutstanding and never underflows (assert both).
- Window check: in_range = (instr_addr_i - BaseAddr) < 4*2**AddrWidth, using unsigned 32-bit subtraction. Addresses below BaseAddr wrap to large values and count as out of range.
- In-range access: word index = (instr_addr_i - BaseAddr)[AddrWidth+1:2].
- Out-of-range access:
  - The request is still granted; the RAM is not read.
  - The response carries rdata = 32'h0000_0000 (an illegal instruction) and instr_err_o = 1.
- The RAM is read synchronously at the accept edge. Data then travels through Latency-1 shift stages, each holding {valid, err, data}.
  - The final stage drives instr_rvalid_o, instr_err_o and instr_rdata_o.
  - Responses are strictly in order. There is no response-side backpressure: the core always consumes rvalid.
- Between responses, instr_rdata_o holds the last returned value and instr_err_o is 0.
- Load port:
  - A write commits at the clock edge and is independent of fetch traffic.
  - If a load write and an accepted read hit the same word in the same cycle, the read returns the old data (read-before-write).
  - A write issued one cycle after an accept does not affect that in-flight response.
- A grant without a request is impossible by construction (assert gnt -> req).

## Timing
- Reset values: instr_rvalid_o 0, instr_err_o 0, instr_rdata_o 32'h0, cnt_q 0, all pipeline valid bits 0. instr_gnt_o is 0 while rst_ni is low. RAM contents are not reset.
- Reset mid-operation: all in-flight responses are discarded, and no rvalid is issued for them after release.
- Accept at edge N produces rvalid high in the cycle after edge N+Latency-1. Latency=1 means rvalid appears in the cycle immediately after the grant cycle.
- Throughput:
  - One accept per cycle is sustained when MaxOutstanding >= Latency. The retire term permits a same-cycle accept at full count.
  - With MaxOutstanding < Latency, gnt deasserts while cnt_q == MaxOutstanding and no response retires that cycle.
- stall_i acts in the same cycle it is asserted; in-flight responses still return on schedule.
- The core may drop or change instr_req_i/instr_addr_i while ungranted. The responder keeps no state for ungranted requests.

## Structure
- No new typedefs are needed in arcino_defines. Add the constant INSTR_ERR_RDATA = 32'h0000_0000 there, so the ID stage and this block share one definition.
- Sub-module arcino_ram_1r1w (parameter AddrWidth):
  - one synchronous read port, one write port, read-before-write;
  - an inferable register array with no reset.
- The top level contains the grant logic, the counter, the window check and the latency shift stages.

## Test plan
- Preload words 0..3 = 32'hA0..A3. Assert req continuously at addresses 0,4,8,12 with Latency=1, MaxOutstanding=2 -> gnt is high every cycle, and rvalid streams A0..A3 one cycle behind each grant.
- Latency=3, MaxOutstanding=1, req held high -> gnt pattern 1,0,0,1,0,0; each rvalid is 3 cycles after its grant; cnt_q stays at or below 1.
- BaseAddr=32'h1000: fetch 32'h0FFC and 32'h5000 -> both are granted; each returns rdata 0 with instr_err_o=1. A fetch at 32'h1004 returns word 1 with err=0.
- Load write of 32'hDEAD to word 5 in the same cycle as an accepted fetch of address 20 -> the response carries the old value. A repeat fetch returns 32'hDEAD.
- stall_i is high for 4 cycles with req high -> no grants and addresses are ignored. Grant resumes in the first cycle stall_i is low.
- Assert rst_ni low with 2 responses in flight (Latency=3) -> no rvalid after release; all outputs are 0; the next fetch returns correct data.
